quadrature_paddle: RTL and testbench
====================================

QUADRATURE_PADDLE -- requirements
Module: quadrature_paddle

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 255: consecutive stable cycles required before a filtered encoder channel changes (range 1..255).
REQ-002 SHALL have parameter COUNTS_PER_STEP, default 4: valid quadrature transitions per paddle step (range 1..8).
REQ-003 SHALL have parameter PADDLE_MAX, default 12: maximum paddle position (range 1..15).
REQ-004 SHALL have parameter PADDLE_INIT, default 6: position loaded at reset (must be <= PADDLE_MAX).
REQ-005 SHALL have port clk32mhz, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports enc_a and enc_b, input, 1 each: raw asynchronous encoder channels from pads.
REQ-008 SHALL have port err_clr, input, 1: clears the sticky error flag.
REQ-009 SHALL have ports step_up and step_down, output, 1 each: single-cycle step pulses.
REQ-010 SHALL have port position, output, 4: registered paddle position.
REQ-011 SHALL have port err, output, 1: sticky illegal-transition flag.

Function
REQ-012 SHALL pass each of enc_a and enc_b through a 2-flop synchronizer.
REQ-013 SHALL produce filtered channels a_f and b_f: debounced per REQ-030, or equal to the synchronizer outputs per REQ-031.
REQ-014 SHALL register the previous filtered pair prev = {a_f, b_f} on every cycle.
REQ-015 SHALL treat 00->01->11->10->00 as a +1 transition and the reverse order as a -1 transition.
REQ-016 SHALL treat no change as idle, with no count and no error.
REQ-017 SHALL treat a change of both bits in one cycle as illegal: set err, leave the accumulator unchanged.
REQ-018 SHALL hold a signed accumulator in the range -(COUNTS_PER_STEP-1)..+(COUNTS_PER_STEP-1).
REQ-019 SHALL, when a +1 transition would bring the accumulator to +COUNTS_PER_STEP, clear it to 0 and assert step_up for exactly one cycle; -1 toward -COUNTS_PER_STEP does likewise with step_down.
REQ-020 SHALL increment position on the step_up edge unless position == PADDLE_MAX, and decrement it on step_down unless position == 0; the step pulse is still emitted when position saturates.
REQ-021 SHALL never assert step_up and step_down in the same cycle.
REQ-022 SHALL, with DEBOUNCE_EN undefined, assert step_up/step_down and update position exactly 3 rising edges after the enc_* edge completing a step, measured from the first edge sampling the new value.
REQ-023 SHALL, with DEBOUNCE_EN defined, add exactly DEBOUNCE_CYCLES edges to that latency.
REQ-024 SHALL clear err on the cycle after err_clr is asserted; if an illegal transition coincides with err_clr, err SHALL end the cycle set (set wins).

Reset
REQ-025 SHALL, while reset is high at a clock edge, clear the synchronizers, a_f, b_f, prev, debounce counters, accumulator, step_up, step_down and err to 0, and load position with PADDLE_INIT.
REQ-026 SHALL, for the first 3 cycles after reset deasserts (arming window), update prev from the filtered channels but suppress all counting and error flagging, so an encoder resting at a nonzero state causes no spurious step or err.
REQ-027 SHALL, when reset asserts mid-operation, abandon any partial accumulator count and any debounce count in progress; no step pulse may be emitted in the reset cycle.

Configuration
REQ-028 SHALL make debouncing conditional on the macro QUADRATURE_DEBOUNCE_EN.
REQ-029 SHALL, with QUADRATURE_DEBOUNCE_EN defined, give each channel an 8-bit counter.
REQ-030 SHALL, with QUADRATURE_DEBOUNCE_EN defined, change the filtered value only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; the counter resets whenever the two are equal, so glitches shorter than that are rejected.
REQ-031 SHALL, without QUADRATURE_DEBOUNCE_EN, instantiate no counter logic and drive a_f/b_f directly from the synchronizers.

Verification
REQ-032 SHALL cover forward rotation: no debounce, COUNTS_PER_STEP=4, reset then 4 forward Gray steps spaced 10 cycles -> one step_up pulse, position 6->7, pulse exactly 3 edges after the 4th input edge.
REQ-033 SHALL cover saturation: 8 forward steps (32 transitions) from position 6 -> position stops at 12, and 8 step_up pulses are still observed.
REQ-034 SHALL cover illegal jump and clear: enc 00->11 in one cycle after arming -> err=1 with no step and accumulator unchanged; err_clr for 1 cycle -> err=0; illegal jump coinciding with err_clr -> err stays 1.
REQ-035 SHALL cover reset during motion: 3 forward transitions, reset for 1 cycle with encoder at 10 -> position=6, no step pulse or err during the arming window, then 4 forward transitions -> exactly one step_up.
REQ-036 SHALL cover debounce (QUADRATURE_DEBOUNCE_EN, DEBOUNCE_CYCLES=8): 5-cycle glitch on enc_a -> no change on a_f; a held edge -> a_f changes 8 edges after the synchronizer output.

Source files
------------

// File: rtl/quadrature_paddle.sv
// Quadrature paddle decoder: 2-flop sync, optional debounce, Gray decode, step accumulator, saturating position.
// Define QUADRATURE_DEBOUNCE_EN to insert a per-channel debounce filter of DEBOUNCE_CYCLES cycles.
module quadrature_paddle #(
    parameter int unsigned DEBOUNCE_CYCLES = 255,
    parameter int unsigned COUNTS_PER_STEP = 4,
    parameter int unsigned PADDLE_MAX      = 12,
    parameter int unsigned PADDLE_INIT     = 6
) (
    input  logic       clk32mhz,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       err_clr,
    output logic       step_up,
    output logic       step_down,
    output logic [3:0] position,
    output logic       err
);

    localparam int unsigned PW = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    localparam logic signed [AW-1:0] ACC_TOP  = AW'(COUNTS_PER_STEP - 1);
    localparam logic signed [AW-1:0] ACC_BOT  = -ACC_TOP;
    localparam logic [PW-1:0]        POS_MAX  = PW'(PADDLE_MAX);
    localparam logic [PW-1:0]        POS_INIT = PW'(PADDLE_INIT);

    // Elaboration-time parameter range checks
    if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..255");
    end
    if (COUNTS_PER_STEP == 0 || COUNTS_PER_STEP > 8) begin : g_bad_counts
        $error("COUNTS_PER_STEP out of range 1..8");
    end
    if (PADDLE_MAX == 0 || PADDLE_MAX > 15 || PADDLE_INIT > PADDLE_MAX) begin : g_bad_paddle
        $error("PADDLE_MAX/PADDLE_INIT out of range");
    end

    // Bit 1 carries channel A, bit 0 channel B
    logic [1:0] sync_q1;
    logic [1:0] sync_q2;
    logic       a_f;
    logic       b_f;

    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            sync_q1 <= 2'b00;
            sync_q2 <= 2'b00;
        end else begin
            sync_q1 <= {enc_a, enc_b};
            sync_q2 <= sync_q1;
        end
    end

`ifdef QUADRATURE_DEBOUNCE_EN
    // Filtered value follows the sync output only after DEBOUNCE_CYCLES consecutive differing cycles
    logic [1:0]    filt;
    logic [DW-1:0] db_cnt [2];

    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            filt <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i]   <= sync_q2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign a_f = filt[1];
    assign b_f = filt[0];
`else
    assign a_f = sync_q2[1];
    assign b_f = sync_q2[0];
`endif

    logic [1:0]           prev;
    logic [1:0]           arm_cnt;
    logic signed [AW-1:0] acc;

    logic                 armed_c;
    logic                 fwd_c;
    logic                 rev_c;
    logic                 ill_c;
    logic signed [AW-1:0] acc_nxt;
    logic                 up_nxt;
    logic                 dn_nxt;
    logic [PW-1:0]        pos_nxt;
    logic                 err_nxt;

    // Gray-code transition decode and step accumulation
    always_comb begin
        fwd_c   = 1'b0;
        rev_c   = 1'b0;
        ill_c   = 1'b0;
        acc_nxt = acc;
        up_nxt  = 1'b0;
        dn_nxt  = 1'b0;
        pos_nxt = position;
        err_nxt = err;
        armed_c = (arm_cnt == 2'd3);

        case ({prev, a_f, b_f})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd_c = armed_c;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev_c = armed_c;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ill_c = armed_c;
            default: ;
        endcase

        if (fwd_c) begin
            if (acc == ACC_TOP) begin
                acc_nxt = '0;
                up_nxt  = 1'b1;
            end else begin
                acc_nxt = acc + 4'sd1;
            end
        end else if (rev_c) begin
            if (acc == ACC_BOT) begin
                acc_nxt = '0;
                dn_nxt  = 1'b1;
            end else begin
                acc_nxt = acc - 4'sd1;
            end
        end

        if (up_nxt && position != POS_MAX) pos_nxt = position + PW'(1);
        if (dn_nxt && position != '0)      pos_nxt = position - PW'(1);

        // A coincident illegal transition takes priority over the clear
        if (ill_c)        err_nxt = 1'b1;
        else if (err_clr) err_nxt = 1'b0;
    end

    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            prev      <= 2'b00;
            arm_cnt   <= 2'd0;
            acc       <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            position  <= POS_INIT;
            err       <= 1'b0;
        end else begin
            prev      <= {a_f, b_f};
            if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
            acc       <= acc_nxt;
            step_up   <= up_nxt;
            step_down <= dn_nxt;
            position  <= pos_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_quadrature_paddle.sv
// Self-checking bench for quadrature_paddle against a Gray-index arithmetic reference model.
module tb_quadrature_paddle;

    localparam int unsigned CPS   = 4;
    localparam int unsigned PMAX  = 12;
    localparam int unsigned PINIT = 6;
`ifdef QUADRATURE_DEBOUNCE_EN
    localparam int unsigned DB  = 8;
    localparam int unsigned LAT = 3 + DB;
`else
    localparam int unsigned DB  = 255;
    localparam int unsigned LAT = 3;
`endif

    logic       clk32mhz = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       err_clr;
    logic       step_up;
    logic       step_down;
    logic [3:0] position;
    logic       err;

    quadrature_paddle #(
        .DEBOUNCE_CYCLES(DB),
        .COUNTS_PER_STEP(CPS),
        .PADDLE_MAX     (PMAX),
        .PADDLE_INIT    (PINIT)
    ) dut (
        .clk32mhz (clk32mhz),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .err_clr  (err_clr),
        .step_up  (step_up),
        .step_down(step_down),
        .position (position),
        .err      (err)
    );

    always #5 clk32mhz = ~clk32mhz;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: encoder phase as a Gray index, integer accumulator and position
    int         m_acc;
    int         m_pos;
    logic       m_err;
    logic [1:0] m_enc;
    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic int gidx(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] neighbour(input logic [1:0] s, input int dir);
        return gray_tab[(gidx(s) + dir + 4) % 4];
    endfunction

    task automatic model_move(input logic [1:0] nxt, output logic eu, output logic ed);
        int d;
        d  = (gidx(nxt) - gidx(m_enc) + 4) % 4;
        eu = 1'b0;
        ed = 1'b0;
        if (d == 1) begin
            m_acc++;
            if (m_acc == int'(CPS)) begin
                m_acc = 0;
                eu    = 1'b1;
                if (m_pos < int'(PMAX)) m_pos++;
            end
        end else if (d == 3) begin
            m_acc--;
            if (m_acc == -int'(CPS)) begin
                m_acc = 0;
                ed    = 1'b1;
                if (m_pos > 0) m_pos--;
            end
        end else if (d == 2) begin
            m_err = 1'b1;
        end
        m_enc = nxt;
    endtask

    task automatic do_reset(input logic [1:0] rest);
        @(negedge clk32mhz);
        reset   = 1'b1;
        err_clr = 1'b0;
        {enc_a, enc_b} = rest;
        repeat (2) @(negedge clk32mhz);
        reset = 1'b0;
        m_acc = 0;
        m_pos = PINIT;
        m_err = 1'b0;
        m_enc = rest;
        repeat (6) @(negedge clk32mhz);
    endtask

    // Drive a new encoder state, watch the LAT edges that follow; no comparison here
    task automatic drive_wait(input logic [1:0] nxt, output int early, output logic up_l, output logic dn_l);
        @(negedge clk32mhz);
        {enc_a, enc_b} = nxt;
        early = 0;
        for (int i = 1; i < int'(LAT); i++) begin
            @(negedge clk32mhz);
            early += int'(step_up | step_down);
        end
        @(negedge clk32mhz);
        up_l = step_up;
        dn_l = step_down;
    endtask

    task automatic idle(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk32mhz);
            pulses += int'(step_up | step_down);
        end
    endtask

    task automatic test_reset();
        int p;
        int e;
        reset   = 1'b1;
        err_clr = 1'b0;
        {enc_a, enc_b} = 2'b00;
        repeat (3) @(negedge clk32mhz);
        n_checks++;
        if ({step_up, step_down, position, err} !== {1'b0, 1'b0, 4'(PINIT), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got up=%b dn=%b pos=%0d err=%b want 0 0 %0d 0",
                     step_up, step_down, position, err, PINIT);
        end
        reset = 1'b0;
        m_acc = 0; m_pos = PINIT; m_err = 1'b0; m_enc = 2'b00;
        e = 0;
        p = 0;
        repeat (6) begin
            @(negedge clk32mhz);
            p += int'(step_up | step_down);
            e += int'(err);
        end
        n_checks++;
        if (p != 0 || e != 0 || position !== 4'(PINIT)) begin
            n_fail++;
            $display("FAIL reset_release: got pulses=%0d err_cycles=%0d pos=%0d want 0 0 %0d", p, e, position, PINIT);
        end
    endtask

    task automatic test_forward();
        logic [1:0] nxt;
        logic eu, ed, up_l, dn_l;
        int early, p;
        do_reset(2'b00);
        for (int k = 0; k < 4; k++) begin
            nxt = neighbour(m_enc, 1);
            model_move(nxt, eu, ed);
            drive_wait(nxt, early, up_l, dn_l);
            n_checks++;
            if (early != 0 || {up_l, dn_l, position, err} !== {eu, ed, 4'(m_pos), m_err}) begin
                n_fail++;
                $display("FAIL forward_%0d: got early=%0d up=%b dn=%b pos=%0d err=%b want 0 %b %b %0d %b",
                         k, early, up_l, dn_l, position, err, eu, ed, m_pos, m_err);
            end
            idle(7, p);
            n_checks++;
            if (p != 0) begin
                n_fail++;
                $display("FAIL forward_gap_%0d: got %0d pulses want 0", k, p);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] nxt;
        logic eu, ed, up_l, dn_l;
        int early, p, ups, dns, bad;
        do_reset(2'b00);
        ups = 0; dns = 0; bad = 0;
        for (int k = 0; k < 32 + 52; k++) begin
            nxt = neighbour(m_enc, (k < 32) ? 1 : -1);
            model_move(nxt, eu, ed);
            drive_wait(nxt, early, up_l, dn_l);
            idle(3, p);
            ups += int'(up_l);
            dns += int'(dn_l);
            if (early != 0 || p != 0 || {up_l, dn_l, position} !== {eu, ed, 4'(m_pos)}) bad++;
            if (k == 31) begin
                n_checks++;
                if (ups != 8 || position !== 4'(PMAX)) begin
                    n_fail++;
                    $display("FAIL sat_high: got ups=%0d pos=%0d want 8 %0d", ups, position, PMAX);
                end
            end
        end
        n_checks++;
        if (dns != 13 || position !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_low: got downs=%0d pos=%0d want 13 0", dns, position);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sat_per_move: got %0d bad moves want 0", bad);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] nxt;
        logic eu, ed, up_l, dn_l;
        int early;
        do_reset(2'b00);
        nxt = m_enc ^ 2'b11;
        model_move(nxt, eu, ed);
        drive_wait(nxt, early, up_l, dn_l);
        n_checks++;
        if (early != 0 || {up_l, dn_l, position, err} !== {1'b0, 1'b0, 4'(m_pos), 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_set: got early=%0d up=%b dn=%b pos=%0d err=%b want 0 0 0 %0d 1",
                     early, up_l, dn_l, position, err, m_pos);
        end
        @(negedge clk32mhz); err_clr = 1'b1;
        @(negedge clk32mhz); err_clr = 1'b0;
        m_err = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b want 0", err);
        end
        // Illegal jump arriving on the same edge as err_clr
        nxt = m_enc ^ 2'b11;
        model_move(nxt, eu, ed);
        @(negedge clk32mhz);
        {enc_a, enc_b} = nxt;
        for (int i = 1; i < int'(LAT); i++) @(negedge clk32mhz);
        err_clr = 1'b1;
        @(negedge clk32mhz);
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b1 || step_up !== 1'b0 || step_down !== 1'b0) begin
            n_fail++;
            $display("FAIL err_set_wins: got err=%b up=%b dn=%b want 1 0 0", err, step_up, step_down);
        end
        // Accumulator untouched by illegal jumps: 4 forward moves complete exactly one step
        for (int k = 0; k < 4; k++) begin
            nxt = neighbour(m_enc, 1);
            model_move(nxt, eu, ed);
            drive_wait(nxt, early, up_l, dn_l);
            n_checks++;
            if (early != 0 || {up_l, dn_l, position} !== {eu, ed, 4'(m_pos)}) begin
                n_fail++;
                $display("FAIL illegal_acc_%0d: got up=%b dn=%b pos=%0d want %b %b %0d",
                         k, up_l, dn_l, position, eu, ed, m_pos);
            end
        end
    endtask

`ifndef QUADRATURE_DEBOUNCE_EN
    task automatic test_reset_during_motion();
        logic [1:0] nxt;
        logic eu, ed, up_l, dn_l;
        int early, p, e;
        do_reset(2'b00);
        for (int k = 0; k < 3; k++) begin
            nxt = neighbour(m_enc, 1);
            model_move(nxt, eu, ed);
            drive_wait(nxt, early, up_l, dn_l);
        end
        @(negedge clk32mhz); reset = 1'b1;
        @(negedge clk32mhz); reset = 1'b0;
        m_acc = 0; m_pos = PINIT; m_err = 1'b0; m_enc = {enc_a, enc_b};
        n_checks++;
        if (position !== 4'(PINIT) || m_enc !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_reset_pos: got pos=%0d enc=%b want %0d 10", position, m_enc, PINIT);
        end
        p = 0; e = 0;
        repeat (6) begin
            @(negedge clk32mhz);
            p += int'(step_up | step_down);
            e += int'(err);
        end
        n_checks++;
        if (p != 0 || e != 0) begin
            n_fail++;
            $display("FAIL arming_quiet: got pulses=%0d err_cycles=%0d want 0 0", p, e);
        end
        p = 0;
        for (int k = 0; k < 4; k++) begin
            nxt = neighbour(m_enc, 1);
            model_move(nxt, eu, ed);
            drive_wait(nxt, early, up_l, dn_l);
            p += early + int'(up_l);
        end
        n_checks++;
        if (p != 1 || position !== 4'(PINIT + 1) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_step: got ups=%0d pos=%0d err=%b want 1 %0d 0", p, position, err, PINIT + 1);
        end
        // Reset landing on the edge that would carry a step pulse
        for (int k = 0; k < 3; k++) begin
            nxt = neighbour(m_enc, 1);
            model_move(nxt, eu, ed);
            drive_wait(nxt, early, up_l, dn_l);
        end
        @(negedge clk32mhz);
        {enc_a, enc_b} = neighbour(m_enc, 1);
        @(negedge clk32mhz);
        @(negedge clk32mhz); reset = 1'b1;
        @(negedge clk32mhz); reset = 1'b0;
        n_checks++;
        if ({step_up, step_down, position} !== {1'b0, 1'b0, 4'(PINIT)}) begin
            n_fail++;
            $display("FAIL reset_on_step: got up=%b dn=%b pos=%0d want 0 0 %0d", step_up, step_down, position, PINIT);
        end
        m_acc = 0; m_pos = PINIT; m_err = 1'b0; m_enc = {enc_a, enc_b};
        repeat (6) @(negedge clk32mhz);
    endtask

    task automatic test_back_to_back();
        int ups;
        logic eu, ed;
        logic [1:0] nxt;
        do_reset(2'b00);
        ups = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk32mhz);
            nxt = neighbour(m_enc, 1);
            model_move(nxt, eu, ed);
            {enc_a, enc_b} = nxt;
            ups += int'(step_up);
        end
        repeat (6) begin
            @(negedge clk32mhz);
            ups += int'(step_up);
        end
        n_checks++;
        if (ups != 2 || position !== 4'(m_pos) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: got ups=%0d pos=%0d err=%b want 2 %0d 0", ups, position, err, m_pos);
        end
    endtask
`endif

    task automatic test_random();
        logic [1:0] nxt;
        logic eu, ed, up_l, dn_l;
        int early, p, r, bad, ups, dns, exp_ups, exp_dns;
        do_reset(2'b00);
        bad = 0; ups = 0; dns = 0; exp_ups = 0; exp_dns = 0;
        for (int k = 0; k < 200; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      nxt = neighbour(m_enc, 1);
            else if (r < 88) nxt = neighbour(m_enc, -1);
            else if (r < 94) nxt = m_enc ^ 2'b11;
            else             nxt = m_enc;
            model_move(nxt, eu, ed);
            drive_wait(nxt, early, up_l, dn_l);
            idle(int'($urandom_range(1, 5)), p);
            ups += int'(up_l); dns += int'(dn_l);
            exp_ups += int'(eu); exp_dns += int'(ed);
            if (early != 0 || p != 0 || {up_l, dn_l, position, err} !== {eu, ed, 4'(m_pos), m_err}) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_move_%0d: got up=%b dn=%b pos=%0d err=%b early=%0d gap=%0d want %b %b %0d %b",
                             k, up_l, dn_l, position, err, early, p, eu, ed, m_pos, m_err);
            end
            if (m_err && $urandom_range(0, 3) == 0) begin
                @(negedge clk32mhz); err_clr = 1'b1;
                @(negedge clk32mhz); err_clr = 1'b0;
                m_err = 1'b0;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL random_moves: got %0d bad moves want 0", bad);
        end
        n_checks++;
        if (ups != exp_ups || dns != exp_dns) begin
            n_fail++;
            $display("FAIL random_totals: got up=%0d dn=%0d want %0d %0d", ups, dns, exp_ups, exp_dns);
        end
    endtask

`ifdef QUADRATURE_DEBOUNCE_EN
    task automatic test_debounce();
        int bad;
        logic eu, ed;
        do_reset(2'b00);
        @(negedge clk32mhz); enc_a = 1'b1;
        repeat (5) @(negedge clk32mhz);
        enc_a = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk32mhz);
            bad += int'(dut.a_f !== 1'b0) + int'(step_up | step_down);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL glitch_reject: got %0d bad cycles want 0", bad);
        end
        model_move(2'b10, eu, ed);
        @(negedge clk32mhz); enc_a = 1'b1;
        repeat (DB + 1) @(negedge clk32mhz);
        n_checks++;
        if (dut.a_f !== 1'b0) begin
            n_fail++;
            $display("FAIL debounce_early: got a_f=%b want 0", dut.a_f);
        end
        @(negedge clk32mhz);
        n_checks++;
        if (dut.a_f !== 1'b1) begin
            n_fail++;
            $display("FAIL debounce_edge: got a_f=%b want 1", dut.a_f);
        end
        @(negedge clk32mhz);
        n_checks++;
        if ({step_up, step_down, position, err} !== {eu, ed, 4'(m_pos), m_err}) begin
            n_fail++;
            $display("FAIL debounce_decode: got up=%b dn=%b pos=%0d err=%b want %b %b %0d %b",
                     step_up, step_down, position, err, eu, ed, m_pos, m_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_saturation();
        test_illegal();
`ifndef QUADRATURE_DEBOUNCE_EN
        test_reset_during_motion();
        test_back_to_back();
`else
        test_debounce();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
